// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - shared types and constants for the dcache state array
//
// Purpose: per-way state layout (valid/dirty/shared), the bit positions
// inside a way slice, the sweep mode encoding and the sweeper FSM states.
package std_cache_pkg;

  localparam int unsigned VALID_BIT  = 0;
  localparam int unsigned DIRTY_BIT  = 1;
  localparam int unsigned SHARED_BIT = 2;

  typedef struct packed {
    logic shared;
    logic dirty;
    logic valid;
  } vldrty_t;

  typedef enum logic {
    SWEEP_CLEAR_ALL = 1'b0,
    SWEEP_INV_CLEAN = 1'b1
  } sweep_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/std_dcache_state_array_if.sv
// rtl/std_dcache_state_array_if.sv - multi-port request/response bundle for the state array
//
// Purpose: groups the per-port request, grant and read-response signals.
// Signals:
//   req, we      per-port request and write enable (master -> slave)
//   index        per-port set index
//   wdata, be    per-port write data and bit-level write enables
//   gnt          one-hot-or-zero combinational grant (slave -> master)
//   rvalid       per-port read valid, one cycle after grant
//   rdata        state of the last granted set, shared by all ports
interface std_dcache_state_array_if #(
  parameter int unsigned NumPorts  = 6,
  parameter int unsigned NumSets   = 256,
  parameter int unsigned NumWays   = 8,
  parameter int unsigned StateBits = 3
);
  localparam int unsigned IdxW  = $clog2(NumSets);
  localparam int unsigned DataW = NumWays * StateBits;

  logic [NumPorts-1:0]            req;
  logic [NumPorts-1:0]            we;
  logic [NumPorts-1:0][IdxW-1:0]  index;
  logic [NumPorts-1:0][DataW-1:0] wdata;
  logic [NumPorts-1:0][DataW-1:0] be;
  logic [NumPorts-1:0]            gnt;
  logic [NumPorts-1:0]            rvalid;
  logic [DataW-1:0]               rdata;

  modport master (
    output req, we, index, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, index, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dcache_state_sweeper.sv
// rtl/dcache_state_sweeper.sv - sweep FSM that initialises and bulk-invalidates the state array
//
// Purpose: walks every set once per sweep, producing a masked write per set.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset (restarts a clear-all sweep)
//   sweep_req_i        level-sampled sweep start, honoured only in IDLE
//   sweep_mode_i       0 = clear all, 1 = invalidate clean lines only
//   set_rdata_i        current contents of the set at sweep_idx_o
//   sweep_we_o         write the set at sweep_idx_o this cycle
//   sweep_idx_o        set being swept
//   sweep_mask_o       bits to overwrite
//   sweep_wval_o       value written into the masked bits
//   grant_ok_o         array is free for client access this cycle
//   busy_o, done_o     sweep in progress / single-cycle completion pulse
module dcache_state_sweeper
  import std_cache_pkg::*;
#(
  parameter int unsigned NumSets   = 256,
  parameter int unsigned NumWays   = 8,
  parameter int unsigned StateBits = 3,
  localparam int unsigned IdxW     = $clog2(NumSets),
  localparam int unsigned DataW    = NumWays * StateBits
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sweep_req_i,
  input  logic             sweep_mode_i,
  input  logic [DataW-1:0] set_rdata_i,
  output logic             sweep_we_o,
  output logic [IdxW-1:0]  sweep_idx_o,
  output logic [DataW-1:0] sweep_mask_o,
  output logic [DataW-1:0] sweep_wval_o,
  output logic             grant_ok_o,
  output logic             busy_o,
  output logic             done_o
);

  sweep_state_e state_q, state_d;
  sweep_mode_e  mode_q, mode_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  vldrty_t way_st;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_SWEEP;
      mode_q  <= SWEEP_CLEAR_ALL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    sweep_we_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sweep_req_i) begin
          mode_d  = sweep_mode_e'(sweep_mode_i);
          cnt_d   = '0;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        sweep_we_o = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == IdxW'(NumSets - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Clean-invalidate needs the live set contents: only ways that are
  // valid and not dirty lose their valid and shared bits.
  always_comb begin
    sweep_mask_o = '0;
    way_st       = '0;
    for (int w = 0; w < int'(NumWays); w++) begin
      way_st = set_rdata_i[w*StateBits +: $bits(vldrty_t)];
      if (mode_q == SWEEP_CLEAR_ALL) begin
        sweep_mask_o[w*StateBits +: StateBits] = '1;
      end else if (way_st.valid && !way_st.dirty) begin
        sweep_mask_o[w*StateBits + VALID_BIT]  = 1'b1;
        sweep_mask_o[w*StateBits + SHARED_BIT] = 1'b1;
      end
    end
  end

  assign sweep_idx_o  = cnt_q;
  assign sweep_wval_o = '0;
  // A sweep request in IDLE takes precedence over client requests.
  assign grant_ok_o   = rst_ni && (state_q == ST_IDLE) && !sweep_req_i;
  assign busy_o       = !rst_ni || (state_q != ST_IDLE);
  assign done_o       = rst_ni && (state_q == ST_DONE);

endmodule

// File: rtl/std_dcache_state_array.sv
// rtl/std_dcache_state_array.sv - arbitrated valid/dirty/shared state store for the L1 dcache
//
// Purpose: one-set-per-cycle state storage shared by several cache clients.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   bus (slave)           per-port req/we/index/wdata/be in; gnt/rvalid/rdata out
//   valid_way_o           per-way valid bits of rdata
//   dirty_way_o           per-way dirty bits of rdata
//   shared_way_o          per-way shared bits of rdata
//   sweep_req_i           start a sweep (IDLE only)
//   sweep_mode_i          0 = clear all, 1 = invalidate clean lines only
//   sweep_busy_o          sweep in progress
//   sweep_done_o          single-cycle pulse at sweep completion
module std_dcache_state_array
  import std_cache_pkg::*;
#(
  parameter int unsigned NumPorts  = 6,
  parameter int unsigned NumSets   = 256,
  parameter int unsigned NumWays   = 8,
  parameter int unsigned StateBits = 3,
  localparam int unsigned IdxW     = $clog2(NumSets),
  localparam int unsigned DataW    = NumWays * StateBits
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  std_dcache_state_array_if.slave   bus,
  output logic [NumWays-1:0]        valid_way_o,
  output logic [NumWays-1:0]        dirty_way_o,
  output logic [NumWays-1:0]        shared_way_o,
  input  logic                      sweep_req_i,
  input  logic                      sweep_mode_i,
  output logic                      sweep_busy_o,
  output logic                      sweep_done_o
);

  logic [DataW-1:0] mem_q [NumSets];

  logic             sweep_we;
  logic [IdxW-1:0]  sweep_idx;
  logic [DataW-1:0] sweep_mask, sweep_wval, sweep_rdata;
  logic             grant_ok;

  logic [NumPorts-1:0] gnt;
  logic [IdxW-1:0]     acc_idx;
  logic                acc_we;
  logic [DataW-1:0]    acc_wdata, acc_be;

  logic [NumPorts-1:0] rvalid_q;
  logic [DataW-1:0]    rdata_q, rdata_out;

  assign sweep_rdata = mem_q[sweep_idx];

  dcache_state_sweeper #(
    .NumSets  (NumSets),
    .NumWays  (NumWays),
    .StateBits(StateBits)
  ) i_sweeper (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sweep_req_i (sweep_req_i),
    .sweep_mode_i(sweep_mode_i),
    .set_rdata_i (sweep_rdata),
    .sweep_we_o  (sweep_we),
    .sweep_idx_o (sweep_idx),
    .sweep_mask_o(sweep_mask),
    .sweep_wval_o(sweep_wval),
    .grant_ok_o  (grant_ok),
    .busy_o      (sweep_busy_o),
    .done_o      (sweep_done_o)
  );

  // Fixed priority: scanning downwards lets the lowest requesting port win.
  always_comb begin
    gnt       = '0;
    acc_idx   = '0;
    acc_we    = 1'b0;
    acc_wdata = '0;
    acc_be    = '0;
    for (int p = int'(NumPorts) - 1; p >= 0; p--) begin
      if (grant_ok && bus.req[p]) begin
        gnt       = '0;
        gnt[p]    = 1'b1;
        acc_idx   = bus.index[p];
        acc_we    = bus.we[p];
        acc_wdata = bus.wdata[p];
        acc_be    = bus.be[p];
      end
    end
  end

  assign bus.gnt = gnt;

  // Sweep writes and client writes never coincide: grants exist only in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (sweep_we) begin
        mem_q[sweep_idx] <= (mem_q[sweep_idx] & ~sweep_mask) | (sweep_wval & sweep_mask);
      end else if (acc_we) begin
        mem_q[acc_idx] <= (mem_q[acc_idx] & ~acc_be) | (acc_wdata & acc_be);
      end
    end
  end

  // Read-before-write: the response carries the set as it was before this edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      if (|gnt) begin
        rdata_q <= mem_q[acc_idx];
      end
    end
  end

  // Outputs are forced to their reset values while rst_ni is low.
  assign bus.rvalid = rst_ni ? rvalid_q : '0;
  assign rdata_out  = rst_ni ? rdata_q : '0;
  assign bus.rdata  = rdata_out;

  for (genvar w = 0; w < int'(NumWays); w++) begin : g_way
    assign valid_way_o[w]  = rdata_out[w*StateBits + VALID_BIT];
    assign dirty_way_o[w]  = rdata_out[w*StateBits + DIRTY_BIT];
    assign shared_way_o[w] = rdata_out[w*StateBits + SHARED_BIT];
  end

endmodule
